// File: rtl/zigzag_encryption_if.sv
// Character stream bundle for the zigzag (rail-fence) encryptor.
// The master drives plaintext and key; the slave returns busy and ciphertext.
interface zigzag_encryption_if #(
  parameter int D_WIDTH   = 8,
  parameter int KEY_WIDTH = 16
);
  logic [D_WIDTH-1:0]   data_i;
  logic                 valid_i;
  logic [KEY_WIDTH-1:0] key;
  logic                 busy;
  logic [D_WIDTH-1:0]   data_o;
  logic                 valid_o;

  modport master (output data_i, valid_i, key, input busy, data_o, valid_o);
  modport slave  (input data_i, valid_i, key, output busy, data_o, valid_o);
endinterface

// File: rtl/zigzag_encryption.sv
// Rail-fence encryptor: buffers plaintext until the start token, then emits
// the characters rail by rail, one per cycle, using a walking position generator.
module zigzag_encryption #(
  parameter int                 D_WIDTH                = 8,
  parameter int                 KEY_WIDTH              = 16,
  parameter int                 MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0] START_ENCRYPTION_TOKEN = 8'hFA
) (
  input  logic               clk,
  input  logic               rst,
  zigzag_encryption_if.slave bus
);
  localparam int NW = $clog2(MAX_NOF_CHARS + 1);
  localparam int AW = $clog2(MAX_NOF_CHARS);
  localparam int PW = $clog2(3 * MAX_NOF_CHARS + 1);
  localparam logic [NW-1:0] MAX_N = NW'(MAX_NOF_CHARS);

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t               state_q, state_d;
  logic [NW-1:0]        n_q, n_d;
  logic [NW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        rails_q, rails_d;
  logic [PW-1:0]        period_q, period_d;
  logic [PW-1:0]        rail_q, rail_d;
  logic [PW-1:0]        pos_q, pos_d;
  logic                 phase_q, phase_d;
  logic [D_WIDTH-1:0]   data_o_q, data_o_d;
  logic                 valid_o_q, valid_o_d;
  logic [D_WIDTH-1:0]   mem_q [MAX_NOF_CHARS];
  logic                 wr_en;

  logic [31:0]   key_w;
  logic [31:0]   n_w;
  logic [PW-1:0] n_ext;
  logic [PW-1:0] rails_calc;
  logic [PW-1:0] step;
  logic [PW-1:0] nxt;

  always_comb begin
    key_w = 32'(bus.key);
    n_w   = 32'(n_q);
    n_ext = PW'(n_q);

    if (key_w <= 32'd1 || n_q == '0)
      rails_calc = PW'(1);
    else if (key_w >= n_w)
      rails_calc = n_ext;
    else
      rails_calc = PW'(key_w);

    // Outer rails stride a full period; middle rails alternate the two partial strides.
    if (rails_q == PW'(1))
      step = PW'(1);
    else if (rail_q == '0 || rail_q == rails_q - PW'(1))
      step = period_q;
    else if (phase_q)
      step = rail_q << 1;
    else
      step = period_q - (rail_q << 1);

    nxt = pos_q + step;
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    rails_d   = rails_q;
    period_d  = period_q;
    rail_d    = rail_q;
    pos_d     = pos_q;
    phase_d   = phase_q;
    data_o_d  = '0;
    valid_o_d = 1'b0;
    wr_en     = 1'b0;

    case (state_q)
      COLLECT: begin
        if (bus.valid_i) begin
          if (bus.data_i == START_ENCRYPTION_TOKEN) begin
            state_d  = EMIT;
            rails_d  = rails_calc;
            period_d = (rails_calc - PW'(1)) << 1;
            rail_d   = '0;
            pos_d    = '0;
            phase_d  = 1'b0;
            cnt_d    = '0;
          end else if (n_q < MAX_N) begin
            wr_en = 1'b1;
            n_d   = n_q + NW'(1);
          end
        end
      end
      EMIT: begin
        if (cnt_q < n_q) begin
          valid_o_d = 1'b1;
          data_o_d  = mem_q[pos_q[AW-1:0]];
          cnt_d     = cnt_q + NW'(1);
          if (nxt >= n_ext) begin
            rail_d  = rail_q + PW'(1);
            pos_d   = rail_q + PW'(1);
            phase_d = 1'b0;
          end else begin
            pos_d   = nxt;
            phase_d = ~phase_q;
          end
        end else begin
          state_d = COLLECT;
          n_d     = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= COLLECT;
      n_q       <= '0;
      cnt_q     <= '0;
      rails_q   <= '0;
      period_q  <= '0;
      rail_q    <= '0;
      pos_q     <= '0;
      phase_q   <= 1'b0;
      data_o_q  <= '0;
      valid_o_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      rails_q   <= rails_d;
      period_q  <= period_d;
      rail_q    <= rail_d;
      pos_q     <= pos_d;
      phase_q   <= phase_d;
      data_o_q  <= data_o_d;
      valid_o_q <= valid_o_d;
    end
  end

  // Message storage needs no reset: only positions below n are ever read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[n_q[AW-1:0]] <= bus.data_i;
  end

  assign bus.busy    = (state_q == EMIT);
  assign bus.data_o  = data_o_q;
  assign bus.valid_o = valid_o_q;
endmodule

// File: tb/tb_zigzag_encryption.sv
// Directed bench for zigzag_encryption: a table of message/key/ciphertext
// records plus hand-written sequences for overflow, busy-time traffic and reset.
module tb_zigzag_encryption;
  localparam logic [7:0] TOKEN = 8'hFA;

  typedef struct packed {
    logic [127:0] msg;
    int           len;
    int           key;
    logic [127:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  zigzag_encryption_if #(.D_WIDTH(8), .KEY_WIDTH(16)) bus ();

  zigzag_encryption #(
    .D_WIDTH(8), .KEY_WIDTH(16), .MAX_NOF_CHARS(50), .START_ENCRYPTION_TOKEN(8'hFA)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] tx [64];
  int         tx_len;
  logic [7:0] exp_b [64];
  int         exp_len;
  logic [7:0] got [64];

  vec_t vecs [9];

  function automatic vec_t mk(string m, int k, string e);
    vec_t v;
    v.msg = '0;
    v.exp = '0;
    v.len = m.len();
    v.key = k;
    for (int i = 0; i < m.len(); i++) v.msg[8*(m.len()-1-i) +: 8] = m[i];
    for (int i = 0; i < e.len(); i++) v.exp[8*(e.len()-1-i) +: 8] = e[i];
    return v;
  endfunction

  task automatic check(string name, int act, int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic send_msg();
    for (int i = 0; i < tx_len; i++) begin
      bus.valid_i = 1'b1;
      bus.data_i  = tx[i];
      @(posedge clk); #1;
    end
  endtask

  // Sends tx[], the token with the given key, then watches the whole busy window.
  task automatic run(string name, int key, bit noise);
    int busy_cyc, nval, idx, pat_err, dat_err, cm;
    busy_cyc = 0; nval = 0; idx = 0; pat_err = 0; dat_err = 0; cm = 0;
    send_msg();
    bus.data_i  = TOKEN;
    bus.valid_i = 1'b1;
    bus.key     = 16'(key);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    while (bus.busy && idx < 200) begin
      busy_cyc++;
      if (bus.valid_o) begin
        if (nval < 64) got[nval] = bus.data_o;
        nval++;
      end else if (bus.data_o != 8'h00) begin
        dat_err++;
      end
      if (bus.valid_o != (idx >= 1 && idx <= exp_len)) pat_err++;
      if (noise) begin
        bus.valid_i = 1'b1;
        bus.key     = 16'd5;
        bus.data_i  = (idx % 4 == 3) ? TOKEN : 8'(88 + idx % 4);
      end
      idx++;
      @(posedge clk); #1;
    end
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    for (int i = 0; i < exp_len; i++)
      if (i >= nval || got[i] != exp_b[i]) cm++;
    check({name, " busy_cycles"}, busy_cyc, exp_len + 1);
    check({name, " valid_count"}, nval, exp_len);
    check({name, " valid_window"}, pat_err, 0);
    check({name, " idle_data_zero"}, dat_err, 0);
    check({name, " char_errors"}, cm, 0);
    check({name, " valid_after_busy"}, int'(bus.valid_o), 0);
  endtask

  initial begin
    int v3, seen;
    rst = 1'b1;
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    bus.key     = '0;
    #1;
    check("reset busy", int'(bus.busy), 0);
    check("reset valid_o", int'(bus.valid_o), 0);
    check("reset data_o", int'(bus.data_o), 0);
    #13 rst = 1'b0;
    @(posedge clk); #1;

    vecs[0] = mk("HELLOWORLD", 3, "HOLELWRDLO");
    vecs[1] = mk("ABCDE",      2, "ACEBD");
    vecs[2] = mk("ABCDE",      1, "ABCDE");
    vecs[3] = mk("ABCDE",      9, "ABCDE");
    vecs[4] = mk("ABCDE",      5, "ABCDE");
    vecs[5] = mk("ABCDEFG",    4, "AGBFCED");
    vecs[6] = mk("ABCD",       3, "ABDC");
    vecs[7] = mk("",           3, "");
    vecs[8] = mk("ABCDE",      0, "ABCDE");

    for (int v = 0; v < 9; v++) begin
      tx_len  = vecs[v].len;
      exp_len = vecs[v].len;
      for (int i = 0; i < tx_len; i++) begin
        tx[i]    = vecs[v].msg[8*(tx_len-1-i) +: 8];
        exp_b[i] = vecs[v].exp[8*(tx_len-1-i) +: 8];
      end
      run($sformatf("vec%0d", v), vecs[v].key, 1'b0);
    end

    // Overflow: 52 characters, only the first 50 survive.
    tx_len = 52;
    for (int i = 0; i < 52; i++) tx[i] = 8'(65 + i);
    exp_len = 50;
    for (int i = 0; i < 50; i++) exp_b[i] = 8'(65 + i);
    run("overflow", 1, 1'b0);

    // Traffic and a key change while emitting must not disturb the message.
    tx_len = 5; exp_len = 5;
    tx[0] = "A"; tx[1] = "B"; tx[2] = "C"; tx[3] = "D"; tx[4] = "E";
    exp_b[0] = "A"; exp_b[1] = "C"; exp_b[2] = "E"; exp_b[3] = "B"; exp_b[4] = "D";
    run("busy_noise", 2, 1'b0 | 1'b1);
    tx_len = 0; exp_len = 0;
    run("after_noise_empty", 2, 1'b0);

    // Reset in the middle of an emission.
    tx_len = 10;
    tx[0] = "H"; tx[1] = "E"; tx[2] = "L"; tx[3] = "L"; tx[4] = "O";
    tx[5] = "W"; tx[6] = "O"; tx[7] = "R"; tx[8] = "L"; tx[9] = "D";
    send_msg();
    bus.data_i = TOKEN; bus.valid_i = 1'b1; bus.key = 16'd3;
    @(posedge clk); #1;
    bus.valid_i = 1'b0; bus.data_i = '0;
    seen = 0;
    for (int c = 0; c < 20 && seen < 3; c++) begin
      if (bus.valid_o) seen++;
      if (seen < 3) begin @(posedge clk); #1; end
    end
    check("rst_mid third_output_seen", seen, 3);
    #2 rst = 1'b1;
    #1;
    check("rst_mid busy", int'(bus.busy), 0);
    check("rst_mid valid_o", int'(bus.valid_o), 0);
    check("rst_mid data_o", int'(bus.data_o), 0);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    v3 = 0;
    for (int c = 0; c < 15; c++) begin
      if (bus.valid_o || bus.busy) v3++;
      @(posedge clk); #1;
    end
    check("rst_mid no_residual_output", v3, 0);
    tx_len = 2; exp_len = 2;
    tx[0] = "A"; tx[1] = "B";
    exp_b[0] = "A"; exp_b[1] = "B";
    run("after_rst", 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/zigzag_encryption.md
ZIGZAG_ENCRYPTION -- requirements
Module: zigzag_encryption

Interface
REQ-001 Parameter D_WIDTH, default 8, character width in bits.
REQ-002 Parameter KEY_WIDTH, default 16, key width in bits.
REQ-003 Parameter MAX_NOF_CHARS, default 50, message buffer depth in characters.
REQ-004 Parameter START_ENCRYPTION_TOKEN, default 8'hFA, end-of-plaintext / start-encryption marker.
REQ-005 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 data_i  input  D_WIDTH  plaintext character, or the token.
REQ-008 valid_i  input  1  data_i qualifier, sampled on each rising clk edge.
REQ-009 key  input  KEY_WIDTH  number of rails (zigzag rows).
REQ-010 busy  output  1  high while a stored message is being encrypted or emitted.
REQ-011 data_o  output  D_WIDTH  ciphertext character.
REQ-012 valid_o  output  1  data_o qualifier, one character per high cycle.

Function
REQ-013 The block SHALL have two states, COLLECT and EMIT; it SHALL leave reset in COLLECT.
REQ-014 In COLLECT, a sampled valid_i=1 with data_i != token SHALL store data_i at position n and increment n.
REQ-015 Characters arriving when n = MAX_NOF_CHARS SHALL be dropped; n SHALL saturate at MAX_NOF_CHARS.
REQ-016 A sampled valid_i=1 with data_i = token in COLLECT SHALL never be stored; it SHALL latch key as K and move to EMIT with busy=1 after that edge.
REQ-017 Effective rail count R SHALL be: 1 if K <= 1; n if K >= n; otherwise K. Period P = 2*(R-1).
REQ-018 In EMIT, characters SHALL be output rail by rail, r = 0..R-1, in ascending position order within each rail; output order SHALL be identical to classic rail-fence encryption.
REQ-019 Position generation: rail r starts at position r; rails 0 and R-1 advance by P; middle rails alternate steps P-2r then 2r, starting with P-2r; a next position >= n SHALL move to the start of rail r+1.
REQ-020 For R = 1, output SHALL be positions 0..n-1 in order.
REQ-021 The first valid_o=1 SHALL occur the cycle after busy rises; valid_o SHALL then stay high for exactly n consecutive cycles, no gaps.
REQ-022 busy SHALL fall on the same edge valid_o falls after the last character; n SHALL clear to 0 on that edge and the block SHALL return to COLLECT.
REQ-023 Token with n = 0: busy SHALL be high for exactly one cycle, valid_o SHALL stay 0.
REQ-024 data_o SHALL be 0 whenever valid_o = 0.
REQ-025 valid_i in EMIT, including a token, SHALL be ignored; key changes after the token edge SHALL not affect the current message.
REQ-026 Position and step arithmetic SHALL be wide enough for MAX_NOF_CHARS + 2*MAX_NOF_CHARS without overflow; no wrap-around is permitted.

Reset
REQ-027 rst=1 SHALL immediately force busy=0, valid_o=0, data_o=0, n=0, state COLLECT, independent of clk.
REQ-028 rst asserted mid-EMIT SHALL abort the message; no further characters of it SHALL be emitted after rst deasserts.
REQ-029 Buffer contents after reset are don't-care; only positions < n SHALL ever be output.

Verification
REQ-030 "HELLOWORLD", token, key=3 -> valid_o high 10 cycles, data_o = "HOLELWRDLO", busy high 11 cycles.
REQ-031 "ABCDE", token, key=2 -> "ACEBD"; same message with key=1 and key=9 -> "ABCDE".
REQ-032 Token with no characters -> busy high 1 cycle, valid_o never high, data_o stays 0.
REQ-033 52 characters 'A'..., token, key=1 -> exactly 50 outputs, the first 50 characters in order.
REQ-034 "ABCDE", token, then valid_i=1 "XYZ" and token during EMIT, key changed to 5 -> output "ACEBD" only; next collection starts empty.
REQ-035 rst pulsed on the 3rd output cycle of "HELLOWORLD"/key=3 -> outputs drop to 0 asynchronously; after release, "AB", token, key=2 -> "AB".
